// File: rtl/ahb_master_ctrl.sv
// AHB-Lite master front end: pipelined address/data phases, in-order responses.
// Optional `ALIGN_CHECK_EN: misaligned or oversized commands are answered with an error instead of being issued.
module ahb_master_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter logic [3:0]  HPROT_DEF = 4'b0011
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic              cmd_signed,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [3:0]        hprot,
   output logic              is_signed,
   output logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   input  logic              hresp,
   input  logic [DATA_W-1:0] hrdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   typedef enum logic {S_RUN, S_ERR} state_e;

   state_e              state_q;
   logic                ap_valid_q, ap_bad_q;
   logic [DATA_W-1:0]   ap_wdata_q;
   logic [ADDR_W-1:0]   haddr_q;
   logic                hwrite_q, is_signed_q;
   logic [2:0]          hsize_q;
   logic [3:0]          hprot_q;
   logic                dp_valid_q, dp_bad_q, dp_write_q;
   logic [DATA_W-1:0]   hwdata_q;
   logic                canc_q, pend_q;
   logic                rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                accept, misalign;

`ifdef ALIGN_CHECK_EN
   assign misalign = (cmd_size > 3'd2) ||
                     ((cmd_size == 3'd1) && cmd_addr[0]) ||
                     ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign cmd_ready = (state_q == S_RUN) && (!ap_valid_q || hready);
   assign accept    = cmd_valid && cmd_ready;

   // Rejected entries ride the pipeline as phantoms so their error response stays in order.
   assign htrans    = {ap_valid_q && !ap_bad_q, 1'b0};
   assign haddr     = haddr_q;
   assign hwrite    = hwrite_q;
   assign hsize     = hsize_q;
   assign hprot     = hprot_q;
   assign is_signed = is_signed_q;
   assign hwdata    = hwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RUN;
         ap_valid_q  <= 1'b0;
         ap_bad_q    <= 1'b0;
         ap_wdata_q  <= '0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= '0;
         hprot_q     <= '0;
         is_signed_q <= 1'b0;
         dp_valid_q  <= 1'b0;
         dp_bad_q    <= 1'b0;
         dp_write_q  <= 1'b0;
         hwdata_q    <= '0;
         canc_q      <= 1'b0;
         pend_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_RUN: begin
               if (pend_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  pend_q      <= 1'b0;
               end
               if (dp_valid_q && !dp_bad_q && hresp && !hready) begin
                  // A command taken on this edge is cancelled along with any held AP entry.
                  state_q    <= S_ERR;
                  ap_valid_q <= 1'b0;
                  canc_q     <= ap_valid_q || accept;
               end else begin
                  if (hready) begin
                     if (dp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= dp_bad_q || hresp;
                        rsp_rdata_q <= (dp_write_q || dp_bad_q) ? '0 : hrdata;
                     end
                     dp_valid_q <= ap_valid_q;
                     dp_bad_q   <= ap_bad_q;
                     dp_write_q <= hwrite_q;
                     if (ap_valid_q && !ap_bad_q && hwrite_q)
                        hwdata_q <= ap_wdata_q;
                     ap_valid_q <= 1'b0;
                  end
                  if (accept) begin
                     ap_valid_q <= 1'b1;
                     ap_bad_q   <= misalign;
                     ap_wdata_q <= cmd_wdata;
                     if (!misalign) begin
                        haddr_q     <= cmd_addr;
                        hwrite_q    <= cmd_write;
                        hsize_q     <= cmd_size;
                        is_signed_q <= cmd_signed;
                        hprot_q     <= HPROT_DEF;
                     end
                  end
               end
            end
            S_ERR: begin
               if (hready) begin
                  state_q     <= S_RUN;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= dp_write_q ? '0 : hrdata;
                  dp_valid_q  <= 1'b0;
                  pend_q      <= canc_q;
                  canc_q      <= 1'b0;
               end
            end
            default: state_q <= S_RUN;
         endcase
      end
   end

endmodule
